// File: rtl/vx_rr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// vx_rr_lock_arbiter
//
// Round-robin arbiter that shares one downstream valid/ready consumer among
// NUM_REQS requesters. The request vector is priority-encoded after masking
// off every index at or below a rotating pointer. The lowest remaining index
// wins. If nothing survives the mask, the lowest set request wins instead.
// When LOCK_ENABLE is set, a grant that the consumer has not accepted is
// frozen in a register until the handshake completes.
//
// Parameters:
//   NUM_REQS     number of requesters (>= 1)
//   LOCK_ENABLE  1 holds an unaccepted grant stable, 0 re-arbitrates each cycle
//   PERF_CTR_W   width of the stall counter
//
// Ports:
//   clk_i           clock, all state updates on the rising edge
//   reset_i         synchronous active-high reset
//   requests_i      per-requester request lines
//   grant_ready_i   consumer accepts the presented grant this cycle
//   grant_valid_o   a grant is presented
//   grant_index_o   winning requester index (0 when no grant)
//   grant_onehot_o  winning requester one-hot (0 when no grant)
//   perf_stalls_o   saturating count of cycles with valid & ~ready
//
// Build option:
//   VX_ARB_PERF_EN  when defined, the stall counter is implemented; when
//                   undefined, perf_stalls_o is tied to zero.
// ---------------------------------------------------------------------------
module vx_rr_lock_arbiter #(
  parameter int NUM_REQS    = 4,
  parameter int LOCK_ENABLE = 1,
  parameter int PERF_CTR_W  = 32
) (
  input  logic                                           clk_i,
  input  logic                                           reset_i,
  input  logic [NUM_REQS-1:0]                            requests_i,
  input  logic                                           grant_ready_i,
  output logic                                           grant_valid_o,
  output logic [((NUM_REQS > 1) ? $clog2(NUM_REQS) : 1)-1:0] grant_index_o,
  output logic [NUM_REQS-1:0]                            grant_onehot_o,
  output logic [PERF_CTR_W-1:0]                          perf_stalls_o
);

  localparam int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  state_q;
  logic [LOG_NUM_REQS-1:0] lastIdx_q;
  logic [LOG_NUM_REQS-1:0] lockIdx_q;

  logic                    reqValid;
  logic                    maskedFound;
  logic [LOG_NUM_REQS-1:0] maskedIdx;
  logic [LOG_NUM_REQS-1:0] anyIdx;
  logic [LOG_NUM_REQS-1:0] winnerIdx;
  logic                    grantValid;
  logic [LOG_NUM_REQS-1:0] grantIdx;

  assign reqValid = |requests_i;

  // The loop walks from the highest index down to the lowest, so the last
  // hit it records is the lowest set bit. It tracks two encodes at once:
  // one over the requests above the pointer, and one over all requests,
  // which is the fallback once the pointer has wrapped.
  always_comb begin
    maskedFound = 1'b0;
    maskedIdx   = '0;
    anyIdx      = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (requests_i[i]) begin
        anyIdx = LOG_NUM_REQS'(i);
        if (LOG_NUM_REQS'(i) > lastIdx_q) begin
          maskedIdx   = LOG_NUM_REQS'(i);
          maskedFound = 1'b1;
        end
      end
    end
    winnerIdx = maskedFound ? maskedIdx : anyIdx;
  end

  // In IDLE the grant comes straight from the live requests, with no added
  // latency. In LOCKED it comes from the frozen index, so a requester that
  // drops its line cannot withdraw a grant the consumer has not yet taken.
  // Reset blanks the outputs immediately.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    if (!reset_i) begin
      if (state_q == LOCKED) begin
        grantValid = 1'b1;
        grantIdx   = lockIdx_q;
      end else if (reqValid) begin
        grantValid = 1'b1;
        grantIdx   = winnerIdx;
      end
    end
  end

  always_comb begin
    grant_onehot_o = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      grant_onehot_o[i] = grantValid && (grantIdx == LOG_NUM_REQS'(i));
    end
  end

  assign grant_valid_o = grantValid;
  assign grant_index_o = grantIdx;

  // Arbitration FSM. The pointer moves only on a completed handshake, so
  // an unaccepted grant never costs a requester its turn. A ready pulse
  // with no grant presented changes nothing.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      lastIdx_q <= LOG_NUM_REQS'(NUM_REQS - 1);
      lockIdx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reqValid) begin
            if (grant_ready_i) begin
              lastIdx_q <= winnerIdx;
            end else if (LOCK_ENABLE != 0) begin
              state_q   <= LOCKED;
              lockIdx_q <= winnerIdx;
            end
          end
        end
        LOCKED: begin
          if (grant_ready_i) begin
            state_q   <= IDLE;
            lastIdx_q <= lockIdx_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef VX_ARB_PERF_EN
  logic [PERF_CTR_W-1:0] stallCnt_q;
  logic [PERF_CTR_W-1:0] stallCnt_d;

  // The stall counter stops at all-ones instead of wrapping, so a long
  // stall can never make the count look small.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (grantValid && !grant_ready_i && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + PERF_CTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign perf_stalls_o = stallCnt_q;
`else
  assign perf_stalls_o = '0;
`endif

endmodule

// File: tb/tb_vx_rr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vx_rr_lock_arbiter
//
// Directed bench for vx_rr_lock_arbiter. It builds three instances:
//   dut      NUM_REQS=4, LOCK_ENABLE=1, driven from a vector table
//   dutNl    NUM_REQS=4, LOCK_ENABLE=0, driven by a hand-written sequence
//   dutOne   NUM_REQS=1, driven by a hand-written sequence
// Inputs change just after the falling edge. Outputs are sampled 1 ns
// later, well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_vx_rr_lock_arbiter;

`ifdef VX_ARB_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [3:0]  requests = '0;
  logic        ready = 1'b0;
  logic        grantValid;
  logic [1:0]  grantIndex;
  logic [3:0]  grantOnehot;
  logic [31:0] perfStalls;

  logic        nlReset = 1'b1;
  logic [3:0]  nlRequests = '0;
  logic        nlReady = 1'b0;
  logic        nlValid;
  logic [1:0]  nlIndex;
  logic [3:0]  nlOnehot;
  logic [31:0] nlStalls;

  logic        oneReset = 1'b1;
  logic [0:0]  oneRequests = '0;
  logic        oneReady = 1'b0;
  logic        oneValid;
  logic [0:0]  oneIndex;
  logic [0:0]  oneOnehot;
  logic [31:0] oneStalls;

  int checks = 0;
  int failures = 0;

  vx_rr_lock_arbiter #(.NUM_REQS(4), .LOCK_ENABLE(1), .PERF_CTR_W(32)) dut (
    .clk_i(clk), .reset_i(reset), .requests_i(requests), .grant_ready_i(ready),
    .grant_valid_o(grantValid), .grant_index_o(grantIndex),
    .grant_onehot_o(grantOnehot), .perf_stalls_o(perfStalls)
  );

  vx_rr_lock_arbiter #(.NUM_REQS(4), .LOCK_ENABLE(0), .PERF_CTR_W(32)) dutNl (
    .clk_i(clk), .reset_i(nlReset), .requests_i(nlRequests), .grant_ready_i(nlReady),
    .grant_valid_o(nlValid), .grant_index_o(nlIndex),
    .grant_onehot_o(nlOnehot), .perf_stalls_o(nlStalls)
  );

  vx_rr_lock_arbiter #(.NUM_REQS(1), .LOCK_ENABLE(1), .PERF_CTR_W(32)) dutOne (
    .clk_i(clk), .reset_i(oneReset), .requests_i(oneRequests), .grant_ready_i(oneReady),
    .grant_valid_o(oneValid), .grant_index_o(oneIndex),
    .grant_onehot_o(oneOnehot), .perf_stalls_o(oneStalls)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic       expValid;
    logic [1:0] expIdx;
    logic [3:0] expOh;
    int         expStalls;
  } vec_t;

  vec_t vecQ[$];

  task automatic addVec(input logic rst, input logic [3:0] req, input logic rdy,
                        input logic ev, input logic [1:0] ei, input logic [3:0] eo,
                        input int es);
    vec_t v;
    v.rst = rst; v.req = req; v.rdy = rdy;
    v.expValid = ev; v.expIdx = ei; v.expOh = eo; v.expStalls = es;
    vecQ.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Wait for the falling edge, drive every requester bus, then let the
  // combinational outputs settle before the caller samples them.
  task automatic applyStimulus(input logic r, input logic [3:0] q, input logic rd,
                               input logic nr, input logic [3:0] nq, input logic nrd,
                               input logic orr, input logic oq, input logic ord);
    @(negedge clk);
    reset = r; requests = q; ready = rd;
    nlReset = nr; nlRequests = nq; nlReady = nrd;
    oneReset = orr; oneRequests = oq; oneReady = ord;
    #1;
  endtask

  task automatic checkNl(input string name, input logic ev, input logic [1:0] ei, input logic [3:0] eo);
    checkOutput({name, ".valid"}, {31'b0, nlValid}, {31'b0, ev});
    checkOutput({name, ".index"}, {30'b0, nlIndex}, {30'b0, ei});
    checkOutput({name, ".onehot"}, {28'b0, nlOnehot}, {28'b0, eo});
  endtask

  task automatic checkOne(input string name, input logic ev);
    checkOutput({name, ".valid"}, {31'b0, oneValid}, {31'b0, ev});
    checkOutput({name, ".index"}, {31'b0, oneIndex}, 32'd0);
    checkOutput({name, ".onehot"}, {31'b0, oneOnehot}, {31'b0, ev});
  endtask

  initial begin
    $display("[TB] start, PerfEn=%0d", PerfEn);

    // Columns: rst, req, rdy | expected valid, index, onehot, stalls so far
    addVec(1, 4'b1111, 1, 0, 2'd0, 4'b0000, 0);
    addVec(1, 4'b1111, 1, 0, 2'd0, 4'b0000, 0);
    addVec(0, 4'b1111, 1, 1, 2'd0, 4'b0001, 0);
    addVec(0, 4'b1111, 1, 1, 2'd1, 4'b0010, 0);
    addVec(0, 4'b1111, 1, 1, 2'd2, 4'b0100, 0);
    addVec(0, 4'b1111, 1, 1, 2'd3, 4'b1000, 0);
    addVec(0, 4'b1111, 1, 1, 2'd0, 4'b0001, 0);
    addVec(0, 4'b1010, 1, 1, 2'd1, 4'b0010, 0);
    addVec(0, 4'b1010, 1, 1, 2'd3, 4'b1000, 0);
    addVec(0, 4'b1010, 1, 1, 2'd1, 4'b0010, 0);
    addVec(0, 4'b1010, 1, 1, 2'd3, 4'b1000, 0);
    addVec(0, 4'b0000, 1, 0, 2'd0, 4'b0000, 0);
    addVec(0, 4'b0100, 0, 1, 2'd2, 4'b0100, 0);
    addVec(0, 4'b0001, 0, 1, 2'd2, 4'b0100, 1);
    addVec(0, 4'b0001, 0, 1, 2'd2, 4'b0100, 2);
    addVec(0, 4'b0001, 1, 1, 2'd2, 4'b0100, 3);
    addVec(0, 4'b0001, 1, 1, 2'd0, 4'b0001, 3);
    addVec(0, 4'b1111, 0, 1, 2'd1, 4'b0010, 3);
    addVec(0, 4'b1111, 0, 1, 2'd1, 4'b0010, 4);
    addVec(1, 4'b1111, 0, 0, 2'd0, 4'b0000, 5);
    addVec(0, 4'b1111, 1, 1, 2'd0, 4'b0001, 0);
    addVec(0, 4'b1111, 1, 1, 2'd1, 4'b0010, 0);

    foreach (vecQ[i]) begin
      applyStimulus(vecQ[i].rst, vecQ[i].req, vecQ[i].rdy, 1, 4'b0000, 0, 1, 0, 0);
      checkOutput($sformatf("main[%0d].valid", i), {31'b0, grantValid}, {31'b0, vecQ[i].expValid});
      checkOutput($sformatf("main[%0d].index", i), {30'b0, grantIndex}, {30'b0, vecQ[i].expIdx});
      checkOutput($sformatf("main[%0d].onehot", i), {28'b0, grantOnehot}, {28'b0, vecQ[i].expOh});
      checkOutput($sformatf("main[%0d].stalls", i), perfStalls,
                  PerfEn ? 32'(vecQ[i].expStalls) : 32'd0);
    end

    // Without locking, the winner follows the live requests while the grant
    // is unaccepted. The pointer still moves only on a handshake.
    applyStimulus(1, 4'b0000, 0, 1, 4'b1111, 0, 1, 0, 0);
    checkNl("nl_reset", 0, 2'd0, 4'b0000);
    applyStimulus(1, 4'b0000, 0, 0, 4'b0100, 0, 1, 0, 0);
    checkNl("nl_grant2", 1, 2'd2, 4'b0100);
    applyStimulus(1, 4'b0000, 0, 0, 4'b0001, 0, 1, 0, 0);
    checkNl("nl_switch0", 1, 2'd0, 4'b0001);
    applyStimulus(1, 4'b0000, 0, 0, 4'b0001, 0, 1, 0, 0);
    checkNl("nl_hold0", 1, 2'd0, 4'b0001);
    applyStimulus(1, 4'b0000, 0, 0, 4'b0001, 1, 1, 0, 0);
    checkNl("nl_accept0", 1, 2'd0, 4'b0001);
    applyStimulus(1, 4'b0000, 0, 0, 4'b0101, 1, 1, 0, 0);
    checkNl("nl_rotate2", 1, 2'd2, 4'b0100);
    checkOutput("nl_stalls", nlStalls, PerfEn ? 32'd3 : 32'd0);

    // A single requester: the grant tracks the request line, except that a
    // locked grant stays valid until it is accepted.
    applyStimulus(1, 4'b0000, 0, 0, 4'b0000, 0, 1, 1, 1);
    checkOne("one_reset", 0);
    applyStimulus(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 1, 1);
    checkOne("one_req1", 1);
    applyStimulus(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 1);
    checkOne("one_req0", 0);
    applyStimulus(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 1, 0);
    checkOne("one_lock", 1);
    applyStimulus(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0);
    checkOne("one_held", 1);
    applyStimulus(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 1);
    checkOne("one_accept", 1);
    applyStimulus(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0);
    checkOne("one_released", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
